// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the 32-bit bus datapath.
// One control step per clock: fetch T0-T2, execute T3-T7, HALT until clear.
module control_sequencer #(
  parameter int OPW = 5
) (
  input  logic        clk,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        con_ff,
  input  logic        stop,
  output logic        run,
  output logic        PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Inportout, Cout, BAout, Rout,
  output logic        PCin, IRin, MARin, Yin, Zin, MDRin, HIin, LOin, Rin, CONin, OutPort,
  output logic        Gra, Grb, Grc,
  output logic        read, write,
  output logic        AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT, IncPC
);

  typedef enum logic [3:0] {
    S_T0 = 4'd0, S_T1 = 4'd1, S_T2 = 4'd2, S_T3 = 4'd3,
    S_T4 = 4'd4, S_T5 = 4'd5, S_T6 = 4'd6, S_T7 = 4'd7, S_HALT = 4'd8
  } state_t;

  localparam logic [OPW-1:0] OP_LD   = OPW'(5'd0);
  localparam logic [OPW-1:0] OP_LDI  = OPW'(5'd1);
  localparam logic [OPW-1:0] OP_ST   = OPW'(5'd2);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(5'd3);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(5'd4);
  localparam logic [OPW-1:0] OP_SHR  = OPW'(5'd5);
  localparam logic [OPW-1:0] OP_SHL  = OPW'(5'd6);
  localparam logic [OPW-1:0] OP_ROR  = OPW'(5'd7);
  localparam logic [OPW-1:0] OP_ROL  = OPW'(5'd8);
  localparam logic [OPW-1:0] OP_AND  = OPW'(5'd9);
  localparam logic [OPW-1:0] OP_OR   = OPW'(5'd10);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(5'd11);
  localparam logic [OPW-1:0] OP_ANDI = OPW'(5'd12);
  localparam logic [OPW-1:0] OP_ORI  = OPW'(5'd13);
  localparam logic [OPW-1:0] OP_MUL  = OPW'(5'd14);
  localparam logic [OPW-1:0] OP_DIV  = OPW'(5'd15);
  localparam logic [OPW-1:0] OP_NEG  = OPW'(5'd16);
  localparam logic [OPW-1:0] OP_NOT  = OPW'(5'd17);
  localparam logic [OPW-1:0] OP_BR   = OPW'(5'd18);
  localparam logic [OPW-1:0] OP_JR   = OPW'(5'd19);
  localparam logic [OPW-1:0] OP_JAL  = OPW'(5'd20);
  localparam logic [OPW-1:0] OP_IN   = OPW'(5'd21);
  localparam logic [OPW-1:0] OP_OUT  = OPW'(5'd22);
  localparam logic [OPW-1:0] OP_MFHI = OPW'(5'd23);
  localparam logic [OPW-1:0] OP_MFLO = OPW'(5'd24);
  localparam logic [OPW-1:0] OP_HALT = OPW'(5'd26);

  state_t         state_r, state_nx_s;
  logic [OPW-1:0] opcode_s;
  logic [3:0]     step_s, last_s;
  logic           alu_en_s;
  logic           unused_ir_s;

  // Final control step of each opcode; nop, halt and unlisted codes end after fetch.
  function automatic logic [3:0] last_step(input logic [OPW-1:0] op);
    case (op)
      OP_LD, OP_ST:                                  last_step = 4'd7;
      OP_MUL, OP_DIV, OP_BR:                         last_step = 4'd6;
      OP_LDI, OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
      OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI:       last_step = 4'd5;
      OP_NEG, OP_NOT, OP_JAL:                        last_step = 4'd4;
      OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO:        last_step = 4'd3;
      default:                                       last_step = 4'd2;
    endcase
  endfunction

  assign opcode_s    = IR[31 -: OPW];
  assign unused_ir_s = ^IR[31-OPW:0];
  assign step_s      = state_r;
  assign last_s      = last_step(opcode_s);

  // Step register; clear aborts any instruction and restarts at T0.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_r <= S_T0;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next step; nop/halt are resolved in T2, so IR must already be valid there.
  always_comb begin
    state_nx_s = state_r;
    if (state_r == S_HALT) begin
      state_nx_s = S_HALT;
    end else if ((state_r == S_T2) && (opcode_s == OP_HALT)) begin
      state_nx_s = S_HALT;
    end else if (step_s == last_s) begin
      if (stop) begin
        state_nx_s = S_HALT;
      end else begin
        state_nx_s = S_T0;
      end
    end else begin
      state_nx_s = state_t'(step_s + 4'd1);
    end
  end

  // Moore strobe decode from the step and, in execute steps, the opcode.
  always_comb begin
    run = 1'b1;
    {PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Inportout, Cout, BAout, Rout} = 10'd0;
    {PCin, IRin, MARin, Yin, Zin, MDRin, HIin, LOin, Rin, CONin, OutPort} = 11'd0;
    {Gra, Grb, Grc, read, write} = 5'd0;
    {AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT, IncPC} = 13'd0;
    alu_en_s = 1'b0;
    if (clear) begin
      run = 1'b1;
    end else begin
      case (state_r)
        S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
        S_T1: begin Zlowout = 1'b1; PCin = 1'b1; read = 1'b1; MDRin = 1'b1; end
        S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
        S_T3: begin
          case (opcode_s)
            OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR,
            OP_ADDI, OP_ANDI, OP_ORI: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
            OP_LDI, OP_LD, OP_ST:     begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
            OP_MUL, OP_DIV:           begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
            OP_NEG, OP_NOT:           begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_en_s = 1'b1; end
            OP_BR:                    begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
            OP_JR:                    begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
            OP_JAL:                   begin PCout = 1'b1; Grb = 1'b1; Rin = 1'b1; end
            OP_IN:                    begin Inportout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            OP_OUT:                   begin Gra = 1'b1; Rout = 1'b1; OutPort = 1'b1; end
            OP_MFHI:                  begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            OP_MFLO:                  begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            default:                  begin alu_en_s = 1'b0; end
          endcase
        end
        S_T4: begin
          case (opcode_s)
            OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR:
                                      begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_en_s = 1'b1; end
            OP_ADDI, OP_ANDI, OP_ORI: begin Cout = 1'b1; Zin = 1'b1; alu_en_s = 1'b1; end
            OP_LDI, OP_LD, OP_ST:     begin Cout = 1'b1; ADD = 1'b1; Zin = 1'b1; end
            OP_MUL, OP_DIV:           begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_en_s = 1'b1; end
            OP_NEG, OP_NOT:           begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            OP_BR:                    begin PCout = 1'b1; Yin = 1'b1; end
            OP_JAL:                   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
            default:                  begin alu_en_s = 1'b0; end
          endcase
        end
        S_T5: begin
          case (opcode_s)
            OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR,
            OP_ADDI, OP_ANDI, OP_ORI, OP_LDI: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            OP_LD, OP_ST:             begin Zlowout = 1'b1; MARin = 1'b1; end
            OP_MUL, OP_DIV:           begin Zlowout = 1'b1; LOin = 1'b1; end
            OP_BR:                    begin Cout = 1'b1; ADD = 1'b1; Zin = 1'b1; end
            default:                  begin alu_en_s = 1'b0; end
          endcase
        end
        S_T6: begin
          case (opcode_s)
            OP_LD:          begin read = 1'b1; MDRin = 1'b1; end
            OP_ST:          begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
            OP_MUL, OP_DIV: begin Zhighout = 1'b1; HIin = 1'b1; end
            OP_BR: begin
              // A not-taken branch still spends T6 as an empty step.
              if (con_ff) begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
              end else begin
                PCin    = 1'b0;
              end
            end
            default:        begin alu_en_s = 1'b0; end
          endcase
        end
        S_T7: begin
          case (opcode_s)
            OP_LD:   begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            OP_ST:   begin write = 1'b1; end
            default: begin alu_en_s = 1'b0; end
          endcase
        end
        S_HALT:  begin run = 1'b0; end
        default: begin run = 1'b0; end
      endcase
      if (alu_en_s) begin
        case (opcode_s)
          OP_ADD, OP_ADDI: ADD = 1'b1;
          OP_SUB:          SUB = 1'b1;
          OP_SHR:          SHR = 1'b1;
          OP_SHL:          SHL = 1'b1;
          OP_ROR:          ROR = 1'b1;
          OP_ROL:          ROL = 1'b1;
          OP_AND, OP_ANDI: AND = 1'b1;
          OP_OR, OP_ORI:   OR  = 1'b1;
          OP_MUL:          MUL = 1'b1;
          OP_DIV:          DIV = 1'b1;
          OP_NEG:          NEG = 1'b1;
          OP_NOT:          NOT = 1'b1;
          default:         ADD = 1'b0;
        endcase
      end else begin
        alu_en_s = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: strobe traces per instruction plus a
// small bus-datapath model that the strobes drive, checked against hand values.
module tb_control_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clear, stop, con_r;
  logic [31:0] IR;
  logic run, PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Inportout, Cout, BAout, Rout;
  logic PCin, IRin, MARin, Yin, Zin, MDRin, HIin, LOin, Rin, CONin, OutPort;
  logic Gra, Grb, Grc, read, write;
  logic AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT, IncPC;

  control_sequencer #(.OPW(5)) dut (
    .clk(clk), .clear(clear), .IR(IR), .con_ff(con_r), .stop(stop), .run(run),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout), .HIout(HIout),
    .LOout(LOout), .Inportout(Inportout), .Cout(Cout), .BAout(BAout), .Rout(Rout),
    .PCin(PCin), .IRin(IRin), .MARin(MARin), .Yin(Yin), .Zin(Zin), .MDRin(MDRin),
    .HIin(HIin), .LOin(LOin), .Rin(Rin), .CONin(CONin), .OutPort(OutPort),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .read(read), .write(write),
    .AND(AND), .OR(OR), .ADD(ADD), .SUB(SUB), .MUL(MUL), .DIV(DIV), .SHR(SHR), .SHL(SHL),
    .ROR(ROR), .ROL(ROL), .NEG(NEG), .NOT(NOT), .IncPC(IncPC)
  );

  logic [38:0] ctl;
  assign ctl = {PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Inportout, Cout, BAout, Rout,
                PCin, IRin, MARin, Yin, Zin, MDRin, HIin, LOin, Rin, CONin, OutPort,
                Gra, Grb, Grc, read, write,
                AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT, IncPC};

  localparam logic [38:0] K_PCOUT = 39'd1 << 38, K_ZHI   = 39'd1 << 37, K_ZLO   = 39'd1 << 36;
  localparam logic [38:0] K_MDRO  = 39'd1 << 35, K_COUT  = 39'd1 << 31, K_BAOUT = 39'd1 << 30;
  localparam logic [38:0] K_ROUT  = 39'd1 << 29, K_PCIN  = 39'd1 << 28, K_IRIN  = 39'd1 << 27;
  localparam logic [38:0] K_MARIN = 39'd1 << 26, K_YIN   = 39'd1 << 25, K_ZIN   = 39'd1 << 24;
  localparam logic [38:0] K_MDRIN = 39'd1 << 23, K_HIIN  = 39'd1 << 22, K_LOIN  = 39'd1 << 21;
  localparam logic [38:0] K_RIN   = 39'd1 << 20, K_CONIN = 39'd1 << 19, K_GRA   = 39'd1 << 17;
  localparam logic [38:0] K_GRB   = 39'd1 << 16, K_GRC   = 39'd1 << 15, K_READ  = 39'd1 << 14;
  localparam logic [38:0] K_WRITE = 39'd1 << 13, K_ADD   = 39'd1 << 10, K_MUL   = 39'd1 << 8;
  localparam logic [38:0] K_INCPC = 39'd1;
  localparam logic [38:0] F0 = K_PCOUT | K_MARIN | K_INCPC | K_ZIN;
  localparam logic [38:0] F1 = K_ZLO | K_PCIN | K_READ | K_MDRIN;
  localparam logic [38:0] F2 = K_MDRO | K_IRIN;

  // Datapath model driven by the DUT strobes.
  logic [31:0] R [16];
  logic [31:0] mem [256];
  logic [31:0] PC, MAR, MDR, Y, HI, LO, bus, cval;
  logic [63:0] Z;
  logic [3:0]  sel;
  logic        pl_reg, pl_mem;
  logic [3:0]  pl_idx;
  logic [7:0]  pl_addr;
  logic [31:0] pl_val;

  assign cval = {{13{IR[18]}}, IR[18:0]};

  always_comb begin
    if (Gra) sel = IR[26:23];
    else if (Grb) sel = IR[22:19];
    else if (Grc) sel = IR[18:15];
    else sel = 4'd0;
  end

  always_comb begin
    if (PCout) bus = PC;
    else if (Zlowout) bus = Z[31:0];
    else if (Zhighout) bus = Z[63:32];
    else if (MDRout) bus = MDR;
    else if (HIout) bus = HI;
    else if (LOout) bus = LO;
    else if (Cout) bus = cval;
    else if (Rout) bus = R[sel];
    else if (BAout) bus = (sel == 4'd0) ? 32'd0 : R[sel];
    else bus = 32'd0;
  end

  always @(posedge clk) begin
    if (clear) begin
      PC <= 32'd0;
      con_r <= 1'b0;
      if (pl_reg) R[pl_idx] <= pl_val;
      if (pl_mem) mem[pl_addr] <= pl_val;
    end else begin
      if (MARin) MAR <= bus;
      if (Yin) Y <= bus;
      if (PCin) PC <= bus;
      if (Rin) R[sel] <= bus;
      if (HIin) HI <= bus;
      if (LOin) LO <= bus;
      if (CONin) con_r <= (bus == 32'd0);
      if (MDRin) MDR <= read ? mem[MAR[7:0]] : bus;
      if (write) mem[MAR[7:0]] <= MDR;
      if (Zin) begin
        if (IncPC) Z <= {32'd0, bus + 32'd1};
        else if (ADD) Z <= {32'd0, Y + bus};
        else if (MUL) Z <= 64'(Y) * 64'(bus);
        else Z <= 64'd0;
      end
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic hold_clear();
    clear = 1'b1; stop = 1'b0; tick();
  endtask

  task automatic preload_reg(input logic [3:0] idx, input logic [31:0] val);
    pl_reg = 1'b1; pl_idx = idx; pl_val = val; tick(); pl_reg = 1'b0;
  endtask

  task automatic preload_mem(input logic [7:0] addr, input logic [31:0] val);
    pl_mem = 1'b1; pl_addr = addr; pl_val = val; tick(); pl_mem = 1'b0;
  endtask

  task automatic release_clear();
    clear = 1'b0; #1;
  endtask

  task automatic test_reset();
    hold_clear();
    n_vec++; if (ctl !== 39'd0) begin n_bad++; $display("FAIL reset_strobes: got %h want 0", ctl); end
    n_vec++; if (run !== 1'b1) begin n_bad++; $display("FAIL reset_run: got %b want 1", run); end
    release_clear();
    n_vec++; if (ctl !== F0) begin n_bad++; $display("FAIL reset_t0: got %h want %h", ctl, F0); end
    IR = 32'h0080_0054;
    for (int k = 0; k < 5; k++) tick();
    n_vec++; if (ctl !== (K_ZLO | K_MARIN)) begin n_bad++; $display("FAIL ld_t5: got %h want %h", ctl, K_ZLO | K_MARIN); end
    #2 clear = 1'b1; #1;
    n_vec++; if (ctl !== 39'd0) begin n_bad++; $display("FAIL abort_strobes: got %h want 0", ctl); end
    n_vec++; if (run !== 1'b1) begin n_bad++; $display("FAIL abort_run: got %b want 1", run); end
    tick();
    release_clear();
    n_vec++; if (ctl !== F0) begin n_bad++; $display("FAIL abort_t0: got %h want %h", ctl, F0); end
  endtask

  task automatic test_add();
    logic [38:0] ev [8];
    ev = '{F0, F1, F2, K_GRB | K_ROUT | K_YIN, K_GRC | K_ROUT | K_ADD | K_ZIN,
           K_ZLO | K_GRA | K_RIN, F0, 39'd0};
    hold_clear(); preload_reg(4'd2, 32'd5); preload_reg(4'd3, 32'd7); preload_reg(4'd1, 32'd0);
    release_clear();
    IR = 32'h1891_8000;
    for (int k = 0; k < 7; k++) begin
      n_vec++; if (ctl !== ev[k]) begin n_bad++; $display("FAIL add_step%0d: got %h want %h", k, ctl, ev[k]); end
      if (k < 6) tick();
    end
    n_vec++; if (R[1] !== 32'd12) begin n_bad++; $display("FAIL add_r1: got %0d want 12", R[1]); end
  endtask

  task automatic test_ld_st();
    logic [38:0] ev [8];
    int wcnt;
    hold_clear(); preload_mem(8'h54, 32'h97); preload_reg(4'd1, 32'd0); release_clear();
    ev = '{F0, F1, F2, K_GRB | K_BAOUT | K_YIN, K_COUT | K_ADD | K_ZIN, K_ZLO | K_MARIN,
           K_READ | K_MDRIN, K_MDRO | K_GRA | K_RIN};
    IR = 32'h0080_0054;
    for (int k = 0; k < 8; k++) begin
      n_vec++; if (ctl !== ev[k]) begin n_bad++; $display("FAIL ld_step%0d: got %h want %h", k, ctl, ev[k]); end
      tick();
    end
    n_vec++; if (R[1] !== 32'h97) begin n_bad++; $display("FAIL ld_r1: got %h want 97", R[1]); end
    ev = '{F0, F1, F2, K_GRB | K_BAOUT | K_YIN, K_COUT | K_ADD | K_ZIN, K_ZLO | K_MARIN,
           K_GRA | K_ROUT | K_MDRIN, K_WRITE};
    IR = 32'h1080_0087;
    wcnt = 0;
    for (int k = 0; k < 8; k++) begin
      n_vec++; if (ctl !== ev[k]) begin n_bad++; $display("FAIL st_step%0d: got %h want %h", k, ctl, ev[k]); end
      if (write) wcnt++;
      tick();
    end
    n_vec++; if (wcnt != 1) begin n_bad++; $display("FAIL st_write_cycles: got %0d want 1", wcnt); end
    n_vec++; if (mem[8'h87] !== 32'h97) begin n_bad++; $display("FAIL st_mem: got %h want 97", mem[8'h87]); end
  endtask

  task automatic test_branch(input logic [31:0] r2, input logic [31:0] pc_exp, input logic [38:0] t6_exp);
    logic [38:0] ev [8];
    ev = '{F0, F1, F2, K_GRA | K_ROUT | K_CONIN, K_PCOUT | K_YIN, K_COUT | K_ADD | K_ZIN,
           t6_exp, F0};
    hold_clear(); preload_reg(4'd2, r2); release_clear();
    IR = 32'h9100_0023;
    for (int k = 0; k < 8; k++) begin
      n_vec++; if (ctl !== ev[k]) begin n_bad++; $display("FAIL br_step%0d: got %h want %h", k, ctl, ev[k]); end
      if (k < 7) tick();
    end
    n_vec++; if (PC !== pc_exp) begin n_bad++; $display("FAIL br_pc: got %0d want %0d", PC, pc_exp); end
  endtask

  task automatic test_mul();
    logic [38:0] ev [8];
    ev = '{F0, F1, F2, K_GRA | K_ROUT | K_YIN, K_GRB | K_ROUT | K_MUL | K_ZIN,
           K_ZLO | K_LOIN, K_ZHI | K_HIIN, F0};
    hold_clear(); preload_reg(4'd3, 32'h8000_0000); preload_reg(4'd1, 32'd2); release_clear();
    IR = 32'h7188_0000;
    for (int k = 0; k < 8; k++) begin
      n_vec++; if (ctl !== ev[k]) begin n_bad++; $display("FAIL mul_step%0d: got %h want %h", k, ctl, ev[k]); end
      if (k < 7) tick();
    end
    n_vec++; if (LO !== 32'd0) begin n_bad++; $display("FAIL mul_lo: got %h want 0", LO); end
    n_vec++; if (HI !== 32'd1) begin n_bad++; $display("FAIL mul_hi: got %h want 1", HI); end
  endtask

  task automatic test_nop(input logic [31:0] ir_val);
    logic [38:0] ev [4];
    ev = '{F0, F1, F2, F0};
    hold_clear(); release_clear();
    IR = ir_val;
    for (int k = 0; k < 4; k++) begin
      n_vec++; if (ctl !== ev[k]) begin n_bad++; $display("FAIL nop_step%0d: got %h want %h", k, ctl, ev[k]); end
      if (k < 3) tick();
    end
  endtask

  task automatic test_halt();
    hold_clear(); release_clear();
    IR = 32'hD000_0000;
    for (int k = 0; k < 3; k++) begin
      n_vec++; if (run !== 1'b1) begin n_bad++; $display("FAIL halt_fetch_run%0d: got %b want 1", k, run); end
      tick();
    end
    for (int k = 0; k < 20; k++) begin
      n_vec++;
      if (run !== 1'b0 || ctl !== 39'd0) begin
        n_bad++; $display("FAIL halt_hold%0d: got run=%b ctl=%h want run=0 ctl=0", k, run, ctl);
      end
      tick();
    end
  endtask

  task automatic test_stop();
    hold_clear(); preload_reg(4'd2, 32'd5); preload_reg(4'd3, 32'd7); preload_reg(4'd1, 32'd0);
    release_clear();
    IR = 32'h1891_8000;
    tick(); stop = 1'b1;
    for (int k = 1; k < 5; k++) tick();
    n_vec++; if (ctl !== (K_ZLO | K_GRA | K_RIN)) begin n_bad++; $display("FAIL stop_t5: got %h want %h", ctl, K_ZLO | K_GRA | K_RIN); end
    tick();
    n_vec++; if (R[1] !== 32'd12) begin n_bad++; $display("FAIL stop_r1: got %0d want 12", R[1]); end
    n_vec++; if (run !== 1'b0 || ctl !== 39'd0) begin n_bad++; $display("FAIL stop_halt: got run=%b ctl=%h want run=0 ctl=0", run, ctl); end
    stop = 1'b0; tick(); tick();
    n_vec++; if (run !== 1'b0) begin n_bad++; $display("FAIL stop_stay: got run=%b want 0", run); end
  endtask

  task automatic test_back_to_back();
    logic [38:0] ev [9];
    ev = '{F0, F1, F2, F0, F1, F2, K_GRB | K_ROUT | K_YIN, K_GRC | K_ROUT | K_ADD | K_ZIN,
           K_ZLO | K_GRA | K_RIN};
    hold_clear(); preload_reg(4'd2, 32'd5); preload_reg(4'd3, 32'd7); release_clear();
    for (int k = 0; k < 9; k++) begin
      if (k == 0) IR = 32'hC800_0000;
      if (k == 3) IR = 32'h1891_8000;
      n_vec++; if (ctl !== ev[k]) begin n_bad++; $display("FAIL b2b_step%0d: got %h want %h", k, ctl, ev[k]); end
      tick();
    end
  endtask

  initial begin
    clear = 1'b1; stop = 1'b0; IR = 32'd0;
    pl_reg = 1'b0; pl_mem = 1'b0; pl_idx = 4'd0; pl_addr = 8'd0; pl_val = 32'd0;
    test_reset();
    test_add();
    test_ld_st();
    test_branch(32'd0, 32'd36, K_ZLO | K_PCIN);
    test_branch(32'd5, 32'd1, 39'd0);
    test_mul();
    test_nop(32'hC800_0000);
    test_nop(32'hF800_0000);
    test_halt();
    test_stop();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired Moore control unit that sequences the 32-bit bus datapath: instruction fetch, decode, execute and halt.
- Drives every datapath control strobe, one control step per clock.
- Sits beside the datapath.
  - Reads IR and the CON_FF result.
  - Drives the register-select, bus-out, register-in, ALU-op and memory strobes.

Parameters:
- OPW, 5: opcode width, taken from IR[31:27].

Ports:
- clk  input  1  system clock, rising-edge
- clear  input  1  asynchronous active-high reset, shared with the datapath
- IR  input  32  instruction register contents; only IR[31:27] is decoded
- con_ff  input  1  branch condition flip-flop output
- stop  input  1  halt request
- run  output  1  high while executing, low in HALT
- PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Inportout, Cout, BAout, Rout  output  1 each  bus drive enables
- PCin, IRin, MARin, Yin, Zin, MDRin, HIin, LOin, Rin, CONin, OutPort  output  1 each  register load enables
- Gra, Grb, Grc  output  1 each  register-field selects
- read, write  output  1 each  memory strobes
- AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT, IncPC  output  1 each  ALU op selects

Behaviour:
- Clock and reset: one clock (clk); reset (clear) is asynchronous and active-high.
- Reset:
  - clear high forces state T0 and run=1.
  - All other outputs are forced 0 while clear is high.
  - clear mid-instruction aborts it; the first T0 after release starts a fresh fetch.
- Output style: Moore outputs are decoded from state (plus IR[31:27] in execute steps). A strobe asserted in step Tn is consumed at the rising edge ending Tn.
- Fetch (every instruction):
  - T0: PCout, MARin, IncPC, Zin
  - T1: Zlowout, PCin, read, MDRin
  - T2: MDRout, IRin
  - T3: decode of IR[31:27]; execute steps follow.
- Opcodes:
  - 00000 ld, 00001 ldi, 00010 st
  - 00011 add, 00100 sub, 00101 shr, 00110 shl, 00111 ror, 01000 rol, 01001 and, 01010 or
  - 01011 addi, 01100 andi, 01101 ori
  - 01110 mul, 01111 div, 10000 neg, 10001 not
  - 10010 br, 10011 jr, 10100 jal
  - 10101 in, 10110 out, 10111 mfhi, 11000 mflo
  - 11001 nop, 11010 halt
  - Unlisted codes execute as nop.
- Execute sequences (steps T3 onward):
  - reg ALU: Grb Rout Yin; Grc Rout op Zin; Zlowout Gra Rin.
  - immediate ALU: Grb Rout Yin; Cout op Zin; Zlowout Gra Rin.
  - ldi: Grb BAout Yin; Cout ADD Zin; Zlowout Gra Rin.
  - ld: Grb BAout Yin; Cout ADD Zin; Zlowout MARin; read MDRin; MDRout Gra Rin.
  - st: Grb BAout Yin; Cout ADD Zin; Zlowout MARin; Gra Rout MDRin (read=0); write.
  - mul/div: Gra Rout Yin; Grb Rout MUL|DIV Zin; Zlowout LOin; Zhighout HIin.
  - neg/not: Grb Rout NEG|NOT Zin; Zlowout Gra Rin.
  - br: Gra Rout CONin; PCout Yin; Cout ADD Zin; then Zlowout PCin only if con_ff=1, else an empty step.
  - jr: Gra Rout PCin.
  - jal: PCout Grb Rin (link register is the rb field); Gra Rout PCin.
  - in: Inportout Gra Rin.
  - out: Gra Rout OutPort.
  - mfhi/mflo: HIout|LOout Gra Rin.
  - nop: no execute steps.
- Cycle counts: fetch 3 plus execute; ld and st take 8, reg ALU takes 6, nop takes 3 (it returns to T0 after T2).
- Strobe exclusivity: exactly one bus-out enable (including BAout) is high in any step that drives the bus. read and write are never high together.
- Step counter: 4 bits, maximum step T7; it never wraps within an instruction.
- halt: enters HALT after T2 with run=0 and all outputs 0. Only clear exits HALT.
- stop:
  - Sampled on the edge that would return to T0. If high, enter HALT instead.
  - stop asserted mid-instruction does not truncate the instruction.

Test Plan:
- Reset: clear pulse while in T5 of ld -> immediately all strobes 0 and run=1; after release, T0 shows PCout=MARin=IncPC=Zin=1.
- add: IR=0x18918000 (add R1,R2,R3), R2=5, R3=7 -> exact 6-cycle strobe trace; Rin with Gra in cycle 6; R1=12 afterwards.
- ld then st: ld R1,0x54(R0) with mem[0x54]=0x97 -> R1=0x97 after 8 cycles; st 0x87(R1) -> mem[0x87]=0x97 and write high for exactly 1 cycle.
- br: brzr with R2=0 (con_ff=1), offset 35 -> PC=old PC+1+35; with R2=5 (con_ff=0) -> PC=old PC+1, and PCin low in step T6.
- mul: R3=0x80000000, R1=2 -> LO=0, HI=1; LOin high in T5, HIin high in T6.
- halt and stop: opcode 11010 -> run=0 after 3 cycles and stays low for 20 cycles; stop raised during an add -> add completes (R1 written), then HALT.
